// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-side bus controller: command codes,
// default peripheral addresses and the controller state encoding.
package mem_bus_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [8:0] LED_ADDR_DEF = 9'h100;
  localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    WR      = 2'b10,
    RESP    = 2'b11
  } state_t;

endpackage

// File: rtl/mem_bus_ctrl_sw_sync.sv
// Parameterised-width two-flop synchroniser for the asynchronous board
// switches. Only instantiated when SW_SYNC_EN is defined.
module sw_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two back-to-back flops to settle metastability before use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-side bus controller. Decodes CPU commands into RAM, LED and switch
// regions, sequences multi-cycle RAM reads and returns a one-cycle
// mem_ready pulse (with bus_err for unmapped addresses / illegal commands).
// Build option: define SW_SYNC_EN to pass sw_in through a two-flop
// synchroniser; otherwise sw_in is sampled directly at the accept edge.
//
// Handshake: the CPU drives mem_cmd/mem_addr/write_data and holds them until
// it sees mem_ready high for one cycle; a command is accepted only in IDLE,
// so the earliest next accept is the IDLE cycle after RESP.
import mem_bus_pkg::*;

module mem_bus_ctrl #(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter int                RAM_AW   = 8,
  parameter int                RD_LAT   = 1,
  parameter logic [ADDR_W-1:0] LED_ADDR = LED_ADDR_DEF,
  parameter logic [ADDR_W-1:0] SW_ADDR  = SW_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              bus_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [7:0]        sw_in,
  output logic [7:0]        led_out,
  output state_t            state_dbg
);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q;
  logic [DATA_W-1:0] read_data_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              ram_we_q;
  logic              mem_ready_q;
  logic              bus_err_q;
  logic              led_pend_q;
  logic [7:0]        led_q;
  logic [7:0]        sw_value;

  logic is_ram, is_led, is_sw;
  logic accept;
  logic acc_rd_ram, acc_rd_sw, acc_wr_ram, acc_wr_led, acc_err;

`ifdef SW_SYNC_EN
  sw_sync #(.W(8)) u_sw_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (sw_in),
    .q_o   (sw_value)
  );
`else
  assign sw_value = sw_in;
`endif

  // Full-width address decode; RAM is everything below 2**RAM_AW.
  assign is_ram = (mem_addr >> RAM_AW) == '0;
  assign is_led = mem_addr == LED_ADDR;
  assign is_sw  = mem_addr == SW_ADDR;
  assign accept = (state_q == IDLE) && (mem_cmd != MNONE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and accept-class decode.
  always_comb begin
    state_d    = state_q;
    acc_rd_ram = 1'b0;
    acc_rd_sw  = 1'b0;
    acc_wr_ram = 1'b0;
    acc_wr_led = 1'b0;
    acc_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_cmd == MREAD) begin
          if (is_ram) begin
            acc_rd_ram = 1'b1;
            state_d    = RD_WAIT;
          end else if (is_sw) begin
            acc_rd_sw = 1'b1;
            state_d   = RESP;
          end else begin
            acc_err = 1'b1;
            state_d = RESP;
          end
        end else if (mem_cmd == MWRITE) begin
          if (is_ram) begin
            acc_wr_ram = 1'b1;
            state_d    = WR;
          end else if (is_led) begin
            acc_wr_led = 1'b1;
            state_d    = WR;
          end else begin
            acc_err = 1'b1;
            state_d = RESP;
          end
        end else if (mem_cmd != MNONE) begin
          acc_err = 1'b1;
          state_d = RESP;
        end
      end
      RD_WAIT: if (cnt_q == 3'd0) state_d = RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch request, count read latency, drive RAM/LED/response regs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      read_data_q <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      led_pend_q  <= 1'b0;
      led_q       <= '0;
    end else begin
      ram_we_q    <= acc_wr_ram;
      mem_ready_q <= (state_d == RESP);
      bus_err_q   <= acc_err;
      if (accept) begin
        ram_addr_q  <= mem_addr[RAM_AW-1:0];
        ram_wdata_q <= write_data;
        led_pend_q  <= acc_wr_led;
      end
      if (acc_rd_ram) cnt_q <= 3'(RD_LAT - 1);
      else if (state_q == RD_WAIT && cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
      if (acc_rd_sw)
        read_data_q <= {{(DATA_W-8){1'b0}}, sw_value};
      else if (acc_err)
        read_data_q <= '0;
      else if (state_q == RD_WAIT && cnt_q == 3'd0)
        read_data_q <= ram_rdata;
      if (state_q == WR && led_pend_q) led_q <= ram_wdata_q[7:0];
    end
  end

  assign read_data = read_data_q;
  assign mem_ready = mem_ready_q;
  assign bus_err   = bus_err_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign led_out   = led_q;
  assign state_dbg = state_q;

endmodule
